// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// The master reads the instruction fields and the zero flag, and drives every mux select and write enable.
interface mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op_code;
  logic [5:0]       funct;
  logic             zero;
  logic [1:0]       alu_srcA;
  logic [2:0]       alu_srcB;
  logic [3:0]       alu_control;
  logic [1:0]       pc_src;
  logic             IorD;
  logic             ir_wr;
  logic             pc_wr;
  logic             mem_wr;
  logic             reg_wr;
  logic             reg_dst;
  logic             mem2reg;
  logic             branch;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op_code, funct, zero,
    output alu_srcA, alu_srcB, alu_control, pc_src, IorD, ir_wr, pc_wr, mem_wr,
           reg_wr, reg_dst, mem2reg, branch, illegal_op, retired
  );

  modport slave (
    output op_code, funct, zero,
    input  alu_srcA, alu_srcB, alu_control, pc_src, IorD, ir_wr, pc_wr, mem_wr,
           reg_wr, reg_dst, mem2reg, branch, illegal_op, retired
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: MEM_WAIT memory wait states, illegal-opcode pulse and retired counter.
// Define MC_BRANCH_EN to add beq/bne/j through the BRANCH and JUMP states.
module mc_control_fsm #(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input logic              clk,
  input logic              rst_n,
  mc_control_fsm_if.master bus
);
  localparam logic [3:0] ALU_OP_AND = 4'h0;
  localparam logic [3:0] ALU_OP_OR  = 4'h1;
  localparam logic [3:0] ALU_OP_ADD = 4'h2;
  localparam logic [3:0] ALU_OP_XOR = 4'h3;
  localparam logic [3:0] ALU_OP_SUB = 4'h6;
  localparam logic [3:0] ALU_OP_SLT = 4'h7;
  localparam logic [3:0] ALU_OP_SLL = 4'h8;
  localparam logic [3:0] ALU_OP_SRL = 4'h9;
  localparam logic [3:0] ALU_OP_SRA = 4'hA;
  localparam logic [3:0] ALU_OP_NOR = 4'hC;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
`ifdef MC_BRANCH_EN
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADR,
    MEM_READ,
    MEM_WRITEBACK,
    MEM_WRITE,
    R_EXECUTE,
    R_WRITEBACK,
    I_EXECUTE,
    I_WRITEBACK,
    ILLEGAL
`ifdef MC_BRANCH_EN
    , BRANCH
    , JUMP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wait_done;

  assign wait_done = (MEM_WAIT == 0) || (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    retired_d  = retired_q;
    case (state_q)
      FETCH: begin
        if (wait_done) state_d = DECODE;
        else           wait_cnt_d = wait_cnt_q + 4'd1;
      end
      DECODE: begin
        case (bus.op_code)
          OP_RTYPE:                                 state_d = R_EXECUTE;
          OP_LW, OP_SW:                             state_d = MEM_ADR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = I_EXECUTE;
`ifdef MC_BRANCH_EN
          OP_BEQ, OP_BNE:                           state_d = BRANCH;
          OP_J:                                     state_d = JUMP;
`endif
          default:                                  state_d = ILLEGAL;
        endcase
      end
      MEM_ADR:   state_d = (bus.op_code == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ: begin
        if (wait_done) state_d = MEM_WRITEBACK;
        else           wait_cnt_d = wait_cnt_q + 4'd1;
      end
      R_EXECUTE: state_d = R_WRITEBACK;
      I_EXECUTE: state_d = I_WRITEBACK;
`ifdef MC_BRANCH_EN
      BRANCH, JUMP,
`endif
      MEM_WRITEBACK, MEM_WRITE, R_WRITEBACK, I_WRITEBACK: begin
        state_d   = FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      default:   state_d = FETCH;
    endcase
    // Every state change clears the wait counter, so FETCH and MEM_READ always start from zero.
    if (state_d != state_q) wait_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    bus.alu_srcA    = 2'b00;
    bus.alu_srcB    = 3'b000;
    bus.alu_control = 4'h0;
    bus.pc_src      = 2'b00;
    bus.IorD        = 1'b0;
    bus.ir_wr       = 1'b0;
    bus.pc_wr       = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.reg_wr      = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem2reg     = 1'b0;
    bus.branch      = 1'b0;
    bus.illegal_op  = 1'b0;
    case (state_q)
      FETCH: begin
        bus.alu_srcB    = 3'b001;
        bus.alu_control = ALU_OP_ADD;
        // With MEM_WAIT=0 the reset state is already the last fetch cycle; keep writes off until release.
        if (wait_done && rst_n) begin
          bus.ir_wr = 1'b1;
          bus.pc_wr = 1'b1;
        end
      end
      DECODE: begin
        bus.alu_control = ALU_OP_ADD;
`ifdef MC_BRANCH_EN
        bus.alu_srcB    = 3'b100;
`endif
      end
      MEM_ADR: begin
        bus.alu_srcA    = 2'b01;
        bus.alu_srcB    = 3'b010;
        bus.alu_control = ALU_OP_ADD;
      end
      MEM_READ:  bus.IorD = 1'b1;
      MEM_WRITEBACK: begin
        bus.mem2reg = 1'b1;
        bus.reg_wr  = 1'b1;
      end
      MEM_WRITE: begin
        bus.IorD   = 1'b1;
        bus.mem_wr = 1'b1;
      end
      R_EXECUTE: begin
        bus.alu_srcA = 2'b01;
        case (bus.funct)
          6'b100000: bus.alu_control = ALU_OP_ADD;
          6'b100010: bus.alu_control = ALU_OP_SUB;
          6'b100100: bus.alu_control = ALU_OP_AND;
          6'b100101: bus.alu_control = ALU_OP_OR;
          6'b100110: bus.alu_control = ALU_OP_XOR;
          6'b100111: bus.alu_control = ALU_OP_NOR;
          6'b101010: bus.alu_control = ALU_OP_SLT;
          6'b000000, 6'b000010, 6'b000011: begin
            bus.alu_srcA    = 2'b10;
            bus.alu_srcB    = 3'b010;
            bus.alu_control = (bus.funct[1:0] == 2'b00) ? ALU_OP_SLL :
                              (bus.funct[1:0] == 2'b10) ? ALU_OP_SRL : ALU_OP_SRA;
          end
          default: begin
            bus.alu_control = ALU_OP_OR;
            bus.illegal_op  = 1'b1;
          end
        endcase
      end
      R_WRITEBACK: begin
        bus.reg_dst = 1'b1;
        bus.reg_wr  = 1'b1;
      end
      I_EXECUTE: begin
        bus.alu_srcA = 2'b01;
        bus.alu_srcB = 3'b011;
        case (bus.op_code)
          OP_SLTI: bus.alu_control = ALU_OP_SLT;
          OP_ANDI: bus.alu_control = ALU_OP_AND;
          OP_ORI:  bus.alu_control = ALU_OP_OR;
          OP_XORI: bus.alu_control = ALU_OP_XOR;
          default: bus.alu_control = ALU_OP_ADD;
        endcase
      end
      I_WRITEBACK: bus.reg_wr = 1'b1;
      ILLEGAL:     bus.illegal_op = 1'b1;
`ifdef MC_BRANCH_EN
      BRANCH: begin
        bus.alu_srcA    = 2'b01;
        bus.alu_control = ALU_OP_SUB;
        bus.pc_src      = 2'b01;
        bus.branch      = 1'b1;
        bus.pc_wr       = (bus.op_code == OP_BNE) ? ~bus.zero : bus.zero;
      end
      JUMP: begin
        bus.pc_src = 2'b10;
        bus.pc_wr  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifndef MC_BRANCH_EN
  logic unused_zero;
  assign unused_zero = bus.zero;
`endif

  assign bus.retired = retired_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle control words for two wait-state settings.
// Branch/jump vectors apply when MC_BRANCH_EN is defined; otherwise those opcodes must trap.
module tb_mc_control_fsm;
  localparam logic [3:0] ALU_AND = 4'h0, ALU_OR  = 4'h1, ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6, ALU_SLT = 4'h7, ALU_SLL = 4'h8;

  // Flag order: IorD ir_wr pc_wr mem_wr reg_wr reg_dst mem2reg branch illegal_op
  localparam logic [8:0] F_NONE  = 9'b000000000;
  localparam logic [8:0] F_FETCH = 9'b011000000;
  localparam logic [8:0] F_IORD  = 9'b100000000;
  localparam logic [8:0] F_MWB   = 9'b000010100;
  localparam logic [8:0] F_MWR   = 9'b100100000;
  localparam logic [8:0] F_RWB   = 9'b000011000;
  localparam logic [8:0] F_IWB   = 9'b000010000;
  localparam logic [8:0] F_ILL   = 9'b000000001;

`ifdef MC_BRANCH_EN
  localparam logic [2:0] DEC_SRCB = 3'd4;
  localparam logic [19:0] W_BR_T = {2'd1, 3'd0, ALU_SUB, 2'd1, 9'b001000010};
  localparam logic [19:0] W_BR_N = {2'd1, 3'd0, ALU_SUB, 2'd1, 9'b000000010};
  localparam logic [19:0] W_JMP  = {2'd0, 3'd0, 4'h0,    2'd2, 9'b001000000};
`else
  localparam logic [2:0] DEC_SRCB = 3'd0;
`endif

  localparam logic [19:0] W_X     = 20'h0;
  localparam logic [19:0] W_FWAIT = {2'd0, 3'd1, ALU_ADD, 2'd0, F_NONE};
  localparam logic [19:0] W_FLAST = {2'd0, 3'd1, ALU_ADD, 2'd0, F_FETCH};
  localparam logic [19:0] W_DEC   = {2'd0, DEC_SRCB, ALU_ADD, 2'd0, F_NONE};
  localparam logic [19:0] W_RADD  = {2'd1, 3'd0, ALU_ADD, 2'd0, F_NONE};
  localparam logic [19:0] W_RSUB  = {2'd1, 3'd0, ALU_SUB, 2'd0, F_NONE};
  localparam logic [19:0] W_RSLL  = {2'd2, 3'd2, ALU_SLL, 2'd0, F_NONE};
  localparam logic [19:0] W_RBAD  = {2'd1, 3'd0, ALU_OR,  2'd0, F_ILL};
  localparam logic [19:0] W_RWB   = {2'd0, 3'd0, ALU_AND, 2'd0, F_RWB};
  localparam logic [19:0] W_IORI  = {2'd1, 3'd3, ALU_OR,  2'd0, F_NONE};
  localparam logic [19:0] W_ISLT  = {2'd1, 3'd3, ALU_SLT, 2'd0, F_NONE};
  localparam logic [19:0] W_IWB   = {2'd0, 3'd0, ALU_AND, 2'd0, F_IWB};
  localparam logic [19:0] W_MADR  = {2'd1, 3'd2, ALU_ADD, 2'd0, F_NONE};
  localparam logic [19:0] W_MRD   = {2'd0, 3'd0, ALU_AND, 2'd0, F_IORD};
  localparam logic [19:0] W_MWB   = {2'd0, 3'd0, ALU_AND, 2'd0, F_MWB};
  localparam logic [19:0] W_MWR   = {2'd0, 3'd0, ALU_AND, 2'd0, F_MWR};
  localparam logic [19:0] W_ILL   = {2'd0, 3'd0, ALU_AND, 2'd0, F_ILL};

  logic clk;
  logic rst_a_n, rst_b_n;
  int   n_chk, n_pass;

  mc_control_fsm_if #(.CNT_W(4))  ifa ();
  mc_control_fsm_if #(.CNT_W(32)) ifb ();

  mc_control_fsm #(.MEM_WAIT(1), .CNT_W(4))  u_dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ifa));
  mc_control_fsm #(.MEM_WAIT(3), .CNT_W(32)) u_dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] ctl(input bit on_b);
    if (on_b)
      return {ifb.alu_srcA, ifb.alu_srcB, ifb.alu_control, ifb.pc_src, ifb.IorD, ifb.ir_wr,
              ifb.pc_wr, ifb.mem_wr, ifb.reg_wr, ifb.reg_dst, ifb.mem2reg, ifb.branch, ifb.illegal_op};
    return {ifa.alu_srcA, ifa.alu_srcB, ifa.alu_control, ifa.pc_src, ifa.IorD, ifa.ir_wr,
            ifa.pc_wr, ifa.mem_wr, ifa.reg_wr, ifa.reg_dst, ifa.mem2reg, ifa.branch, ifa.illegal_op};
  endfunction

  // Starts in the first FETCH cycle, checks every cycle of one instruction, ends in the next FETCH.
  task automatic run_instr(input bit on_b, input string tag, input logic [5:0] op,
                           input logic [5:0] fn, input logic z, input logic [31:0] ret_exp,
                           input logic [0:5][19:0] tail, input int n_tail);
    int w;
    w = on_b ? 3 : 1;
    if (on_b) begin
      ifb.op_code = op; ifb.funct = fn; ifb.zero = z;
    end else begin
      ifa.op_code = op; ifa.funct = fn; ifa.zero = z;
    end
    check({tag, " retired"}, on_b ? ifb.retired : 32'(ifa.retired), ret_exp);
    for (int k = 0; k <= w; k++) begin
      check($sformatf("%s fetch%0d", tag, k + 1), 32'(ctl(on_b)), 32'((k == w) ? W_FLAST : W_FWAIT));
      step();
    end
    check({tag, " decode"}, 32'(ctl(on_b)), 32'(W_DEC));
    step();
    for (int k = 0; k < n_tail; k++) begin
      check($sformatf("%s state%0d", tag, k + 1), 32'(ctl(on_b)), 32'(tail[k]));
      step();
    end
  endtask

  task automatic run_a();
    int ra;
    ra = 0;
    run_instr(0, "add",   6'h00, 6'h20, 1'b0, 32'(ra), {W_RADD, W_RWB, W_X, W_X, W_X, W_X}, 2); ra++;
    run_instr(0, "sub",   6'h00, 6'h22, 1'b0, 32'(ra), {W_RSUB, W_RWB, W_X, W_X, W_X, W_X}, 2); ra++;
    run_instr(0, "sll",   6'h00, 6'h00, 1'b0, 32'(ra), {W_RSLL, W_RWB, W_X, W_X, W_X, W_X}, 2); ra++;
    run_instr(0, "badfn", 6'h00, 6'h3F, 1'b0, 32'(ra), {W_RBAD, W_RWB, W_X, W_X, W_X, W_X}, 2); ra++;
    run_instr(0, "ori",   6'h0D, 6'h00, 1'b0, 32'(ra), {W_IORI, W_IWB, W_X, W_X, W_X, W_X}, 2); ra++;
    run_instr(0, "slti",  6'h0A, 6'h00, 1'b0, 32'(ra), {W_ISLT, W_IWB, W_X, W_X, W_X, W_X}, 2); ra++;
    run_instr(0, "lw_a",  6'h23, 6'h00, 1'b0, 32'(ra), {W_MADR, W_MRD, W_MRD, W_MWB, W_X, W_X}, 4); ra++;
    run_instr(0, "sw_a",  6'h2B, 6'h00, 1'b0, 32'(ra), {W_MADR, W_MWR, W_X, W_X, W_X, W_X}, 2); ra++;
    run_instr(0, "illop", 6'h3F, 6'h00, 1'b0, 32'(ra), {W_ILL, W_X, W_X, W_X, W_X, W_X}, 1);
`ifdef MC_BRANCH_EN
    run_instr(0, "beq_t", 6'h04, 6'h00, 1'b1, 32'(ra), {W_BR_T, W_X, W_X, W_X, W_X, W_X}, 1); ra++;
    run_instr(0, "beq_n", 6'h04, 6'h00, 1'b0, 32'(ra), {W_BR_N, W_X, W_X, W_X, W_X, W_X}, 1); ra++;
    run_instr(0, "bne_t", 6'h05, 6'h00, 1'b0, 32'(ra), {W_BR_T, W_X, W_X, W_X, W_X, W_X}, 1); ra++;
    run_instr(0, "bne_n", 6'h05, 6'h00, 1'b1, 32'(ra), {W_BR_N, W_X, W_X, W_X, W_X, W_X}, 1); ra++;
    run_instr(0, "j",     6'h02, 6'h00, 1'b0, 32'(ra), {W_JMP, W_X, W_X, W_X, W_X, W_X}, 1); ra++;
`else
    run_instr(0, "beq_ill", 6'h04, 6'h00, 1'b1, 32'(ra), {W_ILL, W_X, W_X, W_X, W_X, W_X}, 1);
    run_instr(0, "j_ill",   6'h02, 6'h00, 1'b0, 32'(ra), {W_ILL, W_X, W_X, W_X, W_X, W_X}, 1);
`endif
    while ((ra % 16) != 0) begin
      run_instr(0, "add_fill", 6'h00, 6'h20, 1'b0, 32'(ra % 16), {W_RADD, W_RWB, W_X, W_X, W_X, W_X}, 2);
      ra++;
    end
    check("retired wrap", 32'(ifa.retired), 32'd0);

    // Abort a load in MEM_READ with an asynchronous reset.
    ifa.op_code = 6'h23;
    repeat (4) step();
    check("lw mem_read IorD", 32'(ifa.IorD), 32'd1);
    #2 rst_a_n = 1'b0;
    #1;
    check("async rst ctl", 32'(ctl(1'b0)), 32'(W_FWAIT));
    check("async rst retired", 32'(ifa.retired), 32'd0);
    step();
    check("held rst ctl", 32'(ctl(1'b0)), 32'(W_FWAIT));
    rst_a_n = 1'b1;
    run_instr(0, "add_post", 6'h00, 6'h20, 1'b0, 32'd0, {W_RADD, W_RWB, W_X, W_X, W_X, W_X}, 2);
    check("retired post", 32'(ifa.retired), 32'd1);
  endtask

  task automatic run_b();
    run_instr(1, "lw_b", 6'h23, 6'h00, 1'b0, 32'd0, {W_MADR, W_MRD, W_MRD, W_MRD, W_MRD, W_MWB}, 6);
    run_instr(1, "sw_b", 6'h2B, 6'h00, 1'b0, 32'd1, {W_MADR, W_MWR, W_X, W_X, W_X, W_X}, 2);
    check("b retired", ifb.retired, 32'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ifa.op_code = 6'h00; ifa.funct = 6'h00; ifa.zero = 1'b0;
    ifb.op_code = 6'h00; ifb.funct = 6'h00; ifb.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ctl a", 32'(ctl(1'b0)), 32'(W_FWAIT));
    check("rst ctl b", 32'(ctl(1'b1)), 32'(W_FWAIT));
    check("rst retired a", 32'(ifa.retired), 32'd0);
    check("rst retired b", ifb.retired, 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    fork
      run_a();
      run_b();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
